rgmii_rx_byte_assembler: RTL



---
 rtl/rgmii_pkg.sv | 41 ++++
 rtl/rgmii_inband_status.sv | 61 ++++++
 rtl/rgmii_rx_byte_assembler.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/rgmii_pkg.sv
// Shared definitions for the RGMII receive path: speed encodings, framing
// nibbles, assembler FSM states and in-band status field layout.
package rgmii_pkg;

  // Speed encodings as carried on the speed input and in in-band status.
  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;

  // Framing symbols seen on the nibble-wide 10/100 path.
  localparam logic [3:0] PREAMBLE_NIBBLE = 4'h5;
  localparam logic [3:0] SFD_NIBBLE      = 4'hD;
  localparam logic [7:0] SFD_BYTE        = 8'hD5;

  // Nibble assembler states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    LOW  = 2'd2,
    HIGH = 2'd3
  } rx_state_e;

  // In-band status bit positions within rxd[3:0] during the inter-frame gap.
  localparam int STS_LINK_BIT   = 0;
  localparam int STS_SPEED_LSB  = 1;
  localparam int STS_SPEED_MSB  = 2;
  localparam int STS_DUPLEX_BIT = 3;

  // Same layout as a packed struct so a sampled nibble casts straight in.
  typedef struct packed {
    logic       full_duplex;  // bit 3
    logic [1:0] speed;        // bits 2:1
    logic       link_up;      // bit 0
  } inband_status_t;

  // Both 1x encodings select the byte-wide gigabit path.
  function automatic logic is_gig(input logic [1:0] speed);
    return speed[1];
  endfunction

endpackage

// File: rtl/rgmii_inband_status.sv
// In-band link status decoder: samples rxd[3:0] on idle cycles (dv=0, er=0)
// and updates the status outputs only after the same field has been seen on
// STATUS_DEBOUNCE consecutive qualifying cycles.
module rgmii_inband_status
  import rgmii_pkg::*;
#(
  parameter int STATUS_DEBOUNCE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx_dv,
  input  logic       i_rx_er,
  input  logic [3:0] i_rxd,
  output logic       o_link_up,
  output logic [1:0] o_link_speed,
  output logic       o_full_duplex
);

  localparam logic [3:0] DEBOUNCE_CNT = 4'(STATUS_DEBOUNCE);
  localparam logic [3:0] CNT_MAX      = 4'hF;

  logic           w_qualify;
  logic           w_same;
  logic [3:0]     w_cnt_next;
  inband_status_t w_sample;

  inband_status_t r_prev;
  logic [3:0]     r_cnt;
  inband_status_t r_status;

  assign w_qualify = ~i_rx_dv & ~i_rx_er;
  assign w_sample  = inband_status_t'(i_rxd);

  // A run continues only if a previous sample exists and matches this one.
  assign w_same     = (r_cnt != 4'd0) && (w_sample == r_prev);
  assign w_cnt_next = !w_same           ? 4'd1 :
                      (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 4'd1;

  // Track the run of identical idle samples and commit once it is long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev   <= '0;
      r_cnt    <= 4'd0;
      r_status <= '0;
    end else if (!w_qualify) begin
      // NOTE: state is updated with <= so every register samples pre-edge values.
      r_cnt <= 4'd0;
    end else begin
      r_prev <= w_sample;
      r_cnt  <= w_cnt_next;
      if (w_cnt_next >= DEBOUNCE_CNT) begin
        r_status <= w_sample;
      end
    end
  end

  assign o_link_up     = r_status.link_up;
  assign o_link_speed  = r_status.speed;
  assign o_full_duplex = r_status.full_duplex;

endmodule

// File: rtl/rgmii_rx_byte_assembler.sv
// RGMII receive byte assembler. At 10/100 it pairs SDR nibbles into bytes,
// aligned on preamble/SFD, and strobes out_clk_en once per byte slot. At 1000
// it registers the byte stream straight through with out_clk_en held high.
// In-band link status is decoded in all modes by rgmii_inband_status.
module rgmii_rx_byte_assembler
  import rgmii_pkg::*;
#(
  parameter int STATUS_DEBOUNCE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] speed,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  output logic [7:0] out_rxd,
  output logic       out_rx_dv,
  output logic       out_rx_er,
  output logic       out_clk_en,
  output logic       align_err,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       full_duplex
);

  logic       w_gig;
  logic       w_speed_chg;
  logic [3:0] w_nib;

  rx_state_e  r_state;
  logic [1:0] r_speed_prev;
  logic       r_seen_pre;
  logic [3:0] r_low_nib;
  logic       r_low_er;
  logic [7:0] r_rxd;
  logic       r_rx_dv;
  logic       r_rx_er;
  logic       r_clk_en;
  logic       r_align_err;

  assign w_gig       = is_gig(speed);
  assign w_speed_chg = (speed != r_speed_prev);
  assign w_nib       = gmii_rxd[3:0];

  // Nibble FSM with registered byte outputs; byte slots alternate with the
  // low-nibble cycle, so out_clk_en keeps a steady 1,0 cadence at 10/100.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_speed_prev <= SPEED_10;
      r_seen_pre   <= 1'b0;
      r_low_nib    <= 4'h0;
      r_low_er     <= 1'b0;
      r_rxd        <= 8'h00;
      r_rx_dv      <= 1'b0;
      r_rx_er      <= 1'b0;
      r_clk_en     <= 1'b0;
      r_align_err  <= 1'b0;
    end else begin
      r_speed_prev <= speed;
      r_align_err  <= 1'b0;

      if ((r_state != IDLE) && w_speed_chg) begin
        // Speed changed under a frame: drop it, nothing more is emitted.
        r_state     <= IDLE;
        r_seen_pre  <= 1'b0;
        r_rxd       <= 8'h00;
        r_rx_dv     <= 1'b0;
        r_rx_er     <= 1'b0;
        r_clk_en    <= ~r_clk_en;
        r_align_err <= 1'b1;
      end else if (w_gig) begin
        // Gigabit: one registered byte per clock, FSM parked.
        r_state    <= IDLE;
        r_seen_pre <= 1'b0;
        r_rxd      <= gmii_rxd;
        r_rx_dv    <= gmii_rx_dv;
        r_rx_er    <= gmii_rx_er;
        r_clk_en   <= 1'b1;
      end else begin
        // Default slot: no byte, strobe keeps its alternating phase.
        r_rxd    <= 8'h00;
        r_rx_dv  <= 1'b0;
        r_rx_er  <= 1'b0;
        r_clk_en <= ~r_clk_en;

        case (r_state)
          IDLE: begin
            if (gmii_rx_dv) begin
              r_state    <= HUNT;
              r_seen_pre <= (w_nib == PREAMBLE_NIBBLE);
              if (w_nib != PREAMBLE_NIBBLE) begin
                r_align_err <= 1'b1;
              end
            end
          end

          HUNT: begin
            if (!gmii_rx_dv) begin
              r_state    <= IDLE;
              r_seen_pre <= 1'b0;
            end else if (w_nib == PREAMBLE_NIBBLE) begin
              r_seen_pre <= 1'b1;
            end else if ((w_nib == SFD_NIBBLE) && r_seen_pre) begin
              r_state    <= LOW;
              r_seen_pre <= 1'b0;
              r_rxd      <= SFD_BYTE;
              r_rx_dv    <= 1'b1;
              r_rx_er    <= gmii_rx_er;
              r_clk_en   <= 1'b1;
            end else begin
              r_align_err <= 1'b1;
            end
          end

          LOW: begin
            r_clk_en <= 1'b0;
            if (!gmii_rx_dv) begin
              r_state <= IDLE;
            end else begin
              r_low_nib <= w_nib;
              r_low_er  <= gmii_rx_er;
              r_state   <= HIGH;
            end
          end

          HIGH: begin
            r_clk_en <= 1'b1;
            r_rx_dv  <= 1'b1;
            if (gmii_rx_dv) begin
              r_rxd   <= {w_nib, r_low_nib};
              r_rx_er <= r_low_er | gmii_rx_er;
              r_state <= LOW;
            end else begin
              // Frame ended on an odd nibble: flush the orphan as an error.
              r_rxd       <= {4'h0, r_low_nib};
              r_rx_er     <= 1'b1;
              r_align_err <= 1'b1;
              r_state     <= IDLE;
            end
          end

          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign out_rxd    = r_rxd;
  assign out_rx_dv  = r_rx_dv;
  assign out_rx_er  = r_rx_er;
  assign out_clk_en = r_clk_en;
  assign align_err  = r_align_err;

  rgmii_inband_status #(
    .STATUS_DEBOUNCE(STATUS_DEBOUNCE)
  ) u_inband_status (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx_dv      (gmii_rx_dv),
    .i_rx_er      (gmii_rx_er),
    .i_rxd        (gmii_rxd[3:0]),
    .o_link_up    (link_up),
    .o_link_speed (link_speed),
    .o_full_duplex(full_duplex)
  );

endmodule
